fifo_rd_packer: RTL and testbench
=================================

# fifo_rd_packer

Read-domain consumer of the asynchronous FIFO. It drains DATA_WIDTH-bit entries through the FIFO's read port (r_en/empty/data_out, one-cycle read latency) and packs PACK consecutive entries into one OUT_WIDTH-bit word. That word is presented on a valid/ready stream to downstream logic. It also handles partial-word flush and output backpressure.

## Interface
- DATA_WIDTH, 8, width of one FIFO entry
- PACK, 4, entries per output word; legal range ≥ 2
- OUT_WIDTH, DATA_WIDTH*PACK, derived; not overridden
- CNT_WIDTH, $clog2(PACK+1), derived lane-counter width
- rclk  in  1  read-domain clock; all logic on rising edge
- rrst  in  1  reset, synchronous, active-high
- fifo_empty  in  1  FIFO empty flag (read domain)
- fifo_r_en  out  1  FIFO read enable
- fifo_data  in  DATA_WIDTH  FIFO read data; valid the cycle after fifo_r_en
- flush  in  1  single-cycle request to emit the current partial word
- out_data  out  OUT_WIDTH  packed word; entry k in bits [k*DATA_WIDTH +: DATA_WIDTH]
- out_keep  out  PACK  lane-valid mask; bit k set = lane k holds data
- out_valid  out  1  word valid
- out_ready  in  1  downstream accept
- busy  out  1  cnt≠0 or pend or out_valid or flush_req

## Operation
- Internal state:
  - acc: OUT_WIDTH accumulator.
  - cnt: 0..PACK, lanes filled.
  - pend: 1 bit, read issued last cycle.
  - flush_req: latched flush.
  - Output register: out_data, out_keep, out_valid.
- Capture: if pend, write fifo_data into acc lane cnt and increment cnt.
- Transfer condition: (!out_valid || out_ready) and pend=0, and either cnt==PACK or (flush_req and cnt>0).
- Transfer action:
  - Copy acc to out_data, with unfilled lanes forced to 0.
  - Set out_keep = (1<<cnt)-1.
  - Set out_valid=1 and cnt=0.
  - Clear flush_req if the word was partial or cnt==PACK with flush_req set.
- Issue, combinational: fifo_r_en = !rrst && !fifo_empty && !flush_req && (eff+pend < PACK), where eff = 0 in a transfer cycle, otherwise cnt.
  - The block never over-reads.
  - Total committed lanes never exceed PACK.
- Output handshake:
  - out_valid clears on out_valid && out_ready unless a transfer occurs in the same cycle.
  - out_data and out_keep hold stable while out_valid && !out_ready.
- Flush:
  - flush sets flush_req, which blocks new reads.
  - The partial word is emitted once pend=0 and the output register is free.
  - If cnt==0 and pend==0, flush_req clears next cycle with no output.
  - flush while flush_req is already set has no additional effect.
- Backpressure: at most PACK entries are held in acc plus one word in the output register. Reads stop once acc is committed full.

## Timing
- Reset (rrst high at a rising edge) clears:
  - out_valid=0, out_data=0, out_keep=0.
  - cnt=0, pend=0, flush_req=0, busy=0.
  - fifo_r_en is 0 while rrst is high.
- Reset mid-operation discards acc, the in-flight entry and the output word. rrst is asserted together with the FIFO read-side reset.
- Latency with out_ready=1 and the FIFO non-empty:
  - fifo_r_en is high in cycles 0..PACK-1.
  - Last capture happens at the end of cycle PACK.
  - Transfer occurs in cycle PACK+1.
  - out_valid is high from cycle PACK+2.
- Throughput: PACK entries per PACK+1 cycles in steady state, because one idle cycle per word is spent waiting for the last capture.
- fifo_empty rising while pend=1 does not affect the in-flight capture.

## Test plan
- Reset: hold rrst 3 cycles with fifo_empty=0 -> fifo_r_en=0 throughout; all outputs 0; after release, first fifo_r_en is in the first non-reset cycle.
- Streaming, PACK=4, out_ready=1, FIFO holds 0x11..0x88:
  - Words 0x44332211 then 0x88776655, out_keep=4'b1111.
  - First out_valid 6 cycles after the first fifo_r_en.
  - Second out_valid 5 cycles after the first.
- Backpressure: out_ready=0 for 20 cycles with 12 entries queued:
  - Exactly 8 reads issued.
  - out_data=0x44332211 held stable.
  - After out_ready=1: words 0x44332211, 0x88776655, 0xCCBBAA99 in order, none lost.
- Flush partial: 3 entries 0xA1,0xA2,0xA3, then flush pulse -> out_data=0x00A3A2A1, out_keep=4'b0111. Flush with cnt=0 -> no out_valid; flush_req clear next cycle.
- Sparse FIFO: fifo_empty toggles randomly ->
  - fifo_r_en is never high while fifo_empty=1.
  - Entries appear in arrival order, lane 0 first.
- Mid-word reset: 2 entries captured, 1-cycle rrst pulse, then 0x01..0x04 supplied -> out_valid stays 0 during reset; next word is 0x04030201 with out_keep=4'b1111.

Source files
------------

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: drains the asynchronous FIFO read port and packs PACK consecutive
// entries into one OUT_WIDTH-bit word on a valid/ready stream, with partial-word flush.
module fifo_rd_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK       = 4,
    parameter int OUT_WIDTH  = DATA_WIDTH * PACK,
    parameter int CNT_WIDTH  = $clog2(PACK + 1)
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  fifo_empty,
    output logic                  fifo_r_en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  flush,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic [PACK-1:0]       out_keep,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy
);

    localparam logic [CNT_WIDTH-1:0] CNT_FULL   = CNT_WIDTH'(PACK);
    localparam logic [CNT_WIDTH:0]   FILL_LIMIT = (CNT_WIDTH + 1)'(PACK);

    logic [OUT_WIDTH-1:0] acc_r;
    logic [OUT_WIDTH-1:0] acc_cap_s;
    logic [OUT_WIDTH-1:0] acc_masked_s;
    logic [CNT_WIDTH-1:0] cnt_r;
    logic                 pend_r;
    logic                 flush_req_r;
    logic [OUT_WIDTH-1:0] out_data_r;
    logic [PACK-1:0]      out_keep_r;
    logic                 out_valid_r;
    logic [PACK-1:0]      keep_s;
    logic [CNT_WIDTH:0]   fill_s;
    logic                 xfer_s;
    logic                 issue_s;
    logic                 flush_clr_s;

    // Mask with the low n lanes set.
    function automatic logic [PACK-1:0] lane_mask(input logic [CNT_WIDTH-1:0] n);
        logic [PACK-1:0] m;
        m = {PACK{1'b0}};
        for (int k = 0; k < PACK; k++) begin
            if (CNT_WIDTH'(k) < n) begin
                m[k] = 1'b1;
            end else begin
                m[k] = 1'b0;
            end
        end
        return m;
    endfunction

    // Transfer decision, read issue and flush-request retirement.
    always_comb begin
        xfer_s = (!out_valid_r || out_ready) && !pend_r &&
                 ((cnt_r == CNT_FULL) || (flush_req_r && (cnt_r != {CNT_WIDTH{1'b0}})));
        // A transferring cycle frees all lanes, so the next read counts from zero.
        if (xfer_s) begin
            fill_s = {{CNT_WIDTH{1'b0}}, pend_r};
        end else begin
            fill_s = {1'b0, cnt_r} + {{CNT_WIDTH{1'b0}}, pend_r};
        end
        issue_s = !rrst && !fifo_empty && !flush_req_r && (fill_s < FILL_LIMIT);
        if (flush_req_r) begin
            flush_clr_s = xfer_s || ((cnt_r == {CNT_WIDTH{1'b0}}) && !pend_r);
        end else begin
            flush_clr_s = 1'b0;
        end
    end

    // Lane insertion for the capture path and zero-masking of unfilled lanes on transfer.
    always_comb begin
        keep_s       = lane_mask(cnt_r);
        acc_cap_s    = acc_r;
        acc_masked_s = {OUT_WIDTH{1'b0}};
        for (int k = 0; k < PACK; k++) begin
            if (cnt_r == CNT_WIDTH'(k)) begin
                acc_cap_s[k*DATA_WIDTH +: DATA_WIDTH] = fifo_data;
            end else begin
                acc_cap_s[k*DATA_WIDTH +: DATA_WIDTH] = acc_r[k*DATA_WIDTH +: DATA_WIDTH];
            end
            if (keep_s[k]) begin
                acc_masked_s[k*DATA_WIDTH +: DATA_WIDTH] = acc_r[k*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                acc_masked_s[k*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{1'b0}};
            end
        end
    end

    // Accumulator, lane counter and in-flight read tracking.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            acc_r  <= {OUT_WIDTH{1'b0}};
            cnt_r  <= {CNT_WIDTH{1'b0}};
            pend_r <= 1'b0;
        end else begin
            pend_r <= issue_s;
            if (xfer_s) begin
                cnt_r <= {CNT_WIDTH{1'b0}};
            end else if (pend_r) begin
                acc_r <= acc_cap_s;
                cnt_r <= cnt_r + CNT_WIDTH'(1);
            end
        end
    end

    // Latched flush request; a repeated pulse while pending is absorbed.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            flush_req_r <= 1'b0;
        end else if (flush_req_r) begin
            flush_req_r <= !flush_clr_s;
        end else begin
            flush_req_r <= flush;
        end
    end

    // Output word register with valid/ready handshake.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            out_data_r  <= {OUT_WIDTH{1'b0}};
            out_keep_r  <= {PACK{1'b0}};
            out_valid_r <= 1'b0;
        end else if (xfer_s) begin
            out_data_r  <= acc_masked_s;
            out_keep_r  <= keep_s;
            out_valid_r <= 1'b1;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign fifo_r_en = issue_s;
    assign out_data  = out_data_r;
    assign out_keep  = out_keep_r;
    assign out_valid = out_valid_r;
    assign busy      = (cnt_r != {CNT_WIDTH{1'b0}}) || pend_r || out_valid_r || flush_req_r;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer: drives fifo_rd_packer from a queue-based FIFO model and scores
// every accepted word against words built by grouping read entries in order.
module tb_fifo_rd_packer;

    localparam int DW   = 8;
    localparam int PACK = 4;
    localparam int OW   = DW * PACK;

    logic          rclk;
    logic          rrst;
    logic          fifo_empty;
    logic          fifo_r_en;
    logic [DW-1:0] fifo_data;
    logic          flush;
    logic [OW-1:0] out_data;
    logic [PACK-1:0] out_keep;
    logic          out_valid;
    logic          out_ready;
    logic          busy;

    fifo_rd_packer #(.DATA_WIDTH(DW), .PACK(PACK)) dut (
        .rclk       (rclk),
        .rrst       (rrst),
        .fifo_empty (fifo_empty),
        .fifo_r_en  (fifo_r_en),
        .fifo_data  (fifo_data),
        .flush      (flush),
        .out_data   (out_data),
        .out_keep   (out_keep),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int words_seen = 0;
    bit sparse  = 1'b0;

    logic [DW-1:0]   src_q[$];
    logic [DW-1:0]   grp_q[$];
    logic [OW-1:0]   exp_data_q[$];
    logic [PACK-1:0] exp_keep_q[$];
    int              rise_q[$];

    logic            s_ren, s_valid, busy_after;
    logic [OW-1:0]   s_data;
    logic [PACK-1:0] s_keep;
    logic            last_valid = 1'b0;
    logic            last_ready = 1'b0;
    logic [OW-1:0]   last_data  = '0;
    logic [PACK-1:0] last_keep  = '0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Close the current group of read entries into one expected output word.
    task automatic emit_group();
        logic [OW-1:0]   w;
        logic [PACK-1:0] kp;
        w  = '0;
        kp = '0;
        for (int k = 0; k < grp_q.size(); k++) begin
            w[k*DW +: DW] = grp_q[k];
            kp[k] = 1'b1;
        end
        exp_data_q.push_back(w);
        exp_keep_q.push_back(kp);
        grp_q.delete();
    endtask

    // One clock cycle: sample at #1 after negedge, update the model after posedge.
    task automatic tick();
        logic rd, fl, rs, hs;
        cyc++;
        fifo_empty = (src_q.size() == 0) || (sparse && ($urandom_range(0, 1) == 0));
        #1;
        rd = fifo_r_en; fl = flush; rs = rrst;
        s_ren = rd; s_valid = out_valid; s_data = out_data; s_keep = out_keep;
        check_val("ren_while_empty", 64'(rd & fifo_empty), 64'd0);
        check_val("ren_in_reset", 64'(rd & rs), 64'd0);
        if (last_valid && !last_ready) begin
            check_val("hold_valid", 64'(s_valid), 64'd1);
            check_val("hold_data", 64'(s_data), 64'(last_data));
            check_val("hold_keep", 64'(s_keep), 64'(last_keep));
        end
        if (s_valid && !last_valid) rise_q.push_back(cyc);
        hs = s_valid && out_ready;
        last_valid = s_valid; last_ready = out_ready; last_data = s_data; last_keep = s_keep;
        @(posedge rclk);
        #1;
        if (rs) begin
            grp_q.delete();
            exp_data_q.delete();
            exp_keep_q.delete();
            check_val("rst_valid", 64'(out_valid), 64'd0);
            check_val("rst_data", 64'(out_data), 64'd0);
            check_val("rst_keep", 64'(out_keep), 64'd0);
            check_val("rst_busy", 64'(busy), 64'd0);
            last_valid = 1'b0;
        end else begin
            if (rd && src_q.size() > 0) begin
                fifo_data = src_q.pop_front();
                grp_q.push_back(fifo_data);
                if (grp_q.size() == PACK) emit_group();
            end
            if (hs) begin
                words_seen++;
                if (exp_data_q.size() == 0) begin
                    check_val("unexpected_word", 64'(s_data), 64'hDEAD);
                end else begin
                    check_val("word_data", 64'(s_data), 64'(exp_data_q.pop_front()));
                    check_val("word_keep", 64'(s_keep), 64'(exp_keep_q.pop_front()));
                end
            end
            if (fl && grp_q.size() > 0) emit_group();
        end
        busy_after = busy;
        check_val("hold_bound", 64'(grp_q.size() + PACK * exp_data_q.size() <= 2 * PACK), 64'd1);
        @(negedge rclk);
    endtask

    // Run with out_ready high until the model and the DUT are both idle.
    task automatic drain(input string tag);
        bit done;
        done = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            tick();
            done = (src_q.size() == 0) && (exp_data_q.size() == 0) && (grp_q.size() == 0) && !busy_after;
        end
        check_val(tag, 64'(done), 64'd1);
    endtask

    initial begin
        int c0, reads, w0;
        rrst = 1'b1; flush = 1'b0; out_ready = 1'b1; fifo_data = '0; fifo_empty = 1'b1;
        @(negedge rclk);

        // Reset with data waiting, then streaming with latency measurement.
        for (int i = 1; i <= 8; i++) src_q.push_back(DW'(i * 17));
        repeat (3) tick();
        rrst = 1'b0;
        rise_q.delete();
        tick();
        c0 = cyc;
        check_val("first_ren_after_rst", 64'(s_ren), 64'd1);
        repeat (16) tick();
        check_val("rise_count", 64'(rise_q.size() >= 2), 64'd1);
        if (rise_q.size() >= 2) begin
            check_val("first_valid_lat", 64'(rise_q[0] - c0), 64'd6);
            check_val("second_valid_gap", 64'(rise_q[1] - rise_q[0]), 64'd5);
        end
        check_val("stream_words", 64'(words_seen), 64'd2);
        drain("stream_drain");

        // Backpressure: 12 entries, output stalled for 20 cycles.
        out_ready = 1'b0;
        for (int i = 1; i <= 12; i++) src_q.push_back(DW'(i * 17));
        reads = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (s_ren) reads++;
            if (s_valid) check_val("bp_held_word", 64'(s_data), 64'h44332211);
        end
        check_val("bp_reads", 64'(reads), 64'd8);
        w0 = words_seen;
        drain("bp_drain");
        check_val("bp_words", 64'(words_seen - w0), 64'd3);

        // Partial-word flush, then a flush with nothing accumulated.
        src_q.push_back(8'hA1); src_q.push_back(8'hA2); src_q.push_back(8'hA3);
        repeat (6) tick();
        w0 = words_seen;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_val("flush_exp_word", 64'(exp_data_q.size() == 1 && exp_data_q[0] == 32'h00A3A2A1 &&
                                         exp_keep_q[0] == 4'b0111), 64'd1);
        drain("flush_drain");
        check_val("flush_words", 64'(words_seen - w0), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_val("empty_flush_pending", 64'(busy_after), 64'd1);
        tick();
        check_val("empty_flush_cleared", 64'(busy_after), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("empty_flush_no_word", 64'(s_valid), 64'd0);
        end

        // Mid-word reset discards partial lanes.
        src_q.push_back(8'hE1); src_q.push_back(8'hE2);
        repeat (4) tick();
        rrst = 1'b1;
        tick();
        rrst = 1'b0;
        w0 = words_seen;
        for (int i = 1; i <= 4; i++) src_q.push_back(DW'(i));
        for (int i = 0; i < 12; i++) begin
            tick();
            if (s_valid) check_val("post_rst_word", 64'({s_keep, s_data}), 64'h0F_04030201);
        end
        drain("post_rst_drain");
        check_val("post_rst_words", 64'(words_seen - w0), 64'd1);

        // Sparse FIFO with random backpressure.
        sparse = 1'b1;
        for (int i = 0; i < 40; i++) src_q.push_back(DW'($urandom));
        for (int i = 0; i < 300; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        sparse = 1'b0;
        drain("sparse_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
